// File: rtl/rv32im_csr_unit.sv
// rv32im_csr_unit: Zicsr instruction sequencer between execute and the CSR register file.
// Takes one decoded CSR instruction, performs the required read and/or write of the CSR file,
// checks access legality and returns the old CSR value for rd.
module rv32im_csr_unit #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CSR_ADDR_W = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // request from execute
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [2:0]            req_funct3_i,
   input  logic [CSR_ADDR_W-1:0] req_addr_i,
   input  logic [XLEN-1:0]       req_rs1_val_i,
   input  logic [4:0]            req_rs1_idx_i,
   input  logic [4:0]            req_rd_idx_i,
   input  logic [1:0]            priv_i,
   // CSR file port
   output logic [CSR_ADDR_W-1:0] csr_addr_o,
   output logic                  csr_re_o,
   output logic                  csr_we_o,
   output logic [XLEN-1:0]       csr_wdata_o,
   input  logic [XLEN-1:0]       csr_rdata_i,
   // response to writeback
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [XLEN-1:0]       resp_rd_data_o,
   output logic [4:0]            resp_rd_idx_o,
   output logic                  resp_illegal_o
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e state_q, state_d;

   // Latched request fields
   logic [1:0]            op_q;
   logic [CSR_ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]       src_q;
   logic [4:0]            rd_idx_q;
   logic                  do_write_q;
   logic                  illegal_q;
   logic [XLEN-1:0]       old_q;

   // Request decode, valid only for the instruction currently offered
   logic [1:0]      req_op;
   logic [XLEN-1:0] req_src;
   logic            req_do_read;
   logic            req_do_write;
   logic            req_illegal;
   logic            accept;
   logic [XLEN-1:0] new_val;

   // Decode operand, read/write needs and legality of the offered instruction
   always_comb begin
      req_op       = req_funct3_i[1:0];
      req_src      = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_val_i;
      req_do_read  = !((req_op == 2'b01) && (req_rd_idx_i == 5'd0));
      req_do_write = (req_op == 2'b01) || (req_rs1_idx_i != 5'd0);
      // op 00 covers the reserved funct3 encodings 000 and 100
      req_illegal  = (req_op == 2'b00) ||
                     (req_addr_i[9:8] > priv_i) ||
                     (req_do_write && (req_addr_i[11:10] == 2'b11));
      accept       = req_valid_i && (state_q == StIdle);
   end

   // Read-modify-write value from the captured old value
   always_comb begin
      new_val = src_q;
      case (op_q)
         2'b10:   new_val = old_q | src_q;
         2'b11:   new_val = old_q & ~src_q;
         default: new_val = src_q;
      endcase
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_illegal) begin
                  state_d = StResp;
               end else if (req_do_read) begin
                  state_d = StRead;
               end else begin
                  state_d = StWrite;
               end
            end
         end
         StRead:  state_d = do_write_q ? StWrite : StResp;
         StWrite: state_d = StResp;
         StResp:  state_d = resp_ready_i ? StIdle : StResp;
         default: state_d = StIdle;
      endcase
   end

   // Request latch and old-value capture; old is zeroed on accept so skipped reads return 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q       <= 2'b00;
         addr_q     <= '0;
         src_q      <= '0;
         rd_idx_q   <= 5'd0;
         do_write_q <= 1'b0;
         illegal_q  <= 1'b0;
         old_q      <= '0;
      end else if (accept) begin
         op_q       <= req_op;
         addr_q     <= req_addr_i;
         src_q      <= req_src;
         rd_idx_q   <= req_rd_idx_i;
         do_write_q <= req_do_write;
         illegal_q  <= req_illegal;
         old_q      <= '0;
      end else if (state_q == StRead) begin
         old_q      <= csr_rdata_i;
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      req_ready_o    = 1'b0;
      csr_addr_o     = '0;
      csr_re_o       = 1'b0;
      csr_we_o       = 1'b0;
      csr_wdata_o    = '0;
      resp_valid_o   = 1'b0;
      resp_rd_data_o = old_q;
      resp_rd_idx_o  = rd_idx_q;
      resp_illegal_o = illegal_q;
      unique case (state_q)
         StIdle: req_ready_o = 1'b1;
         StRead: begin
            csr_addr_o = addr_q;
            csr_re_o   = 1'b1;
         end
         StWrite: begin
            csr_addr_o  = addr_q;
            csr_we_o    = 1'b1;
            csr_wdata_o = new_val;
         end
         StResp: resp_valid_o = 1'b1;
         default: req_ready_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_rv32im_csr_unit.sv
// Directed bench for rv32im_csr_unit: table of single instructions plus hand sequences for
// response backpressure and reset in the middle of a read-modify-write.
module tb_rv32im_csr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [31:0] req_rs1_val;
   logic [4:0]  req_rs1_idx;
   logic [4:0]  req_rd_idx;
   logic [1:0]  priv;
   logic [11:0] csr_addr;
   logic        csr_re;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rd_data;
   logic [4:0]  resp_rd_idx;
   logic        resp_illegal;

   // CSR file model with a bench-side preload port
   logic [31:0] mem [0:4095];
   logic        pl_en;
   logic [11:0] pl_addr;
   logic [31:0] pl_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rv32im_csr_unit #(.XLEN(32), .CSR_ADDR_W(12)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_funct3_i   (req_funct3),
      .req_addr_i     (req_addr),
      .req_rs1_val_i  (req_rs1_val),
      .req_rs1_idx_i  (req_rs1_idx),
      .req_rd_idx_i   (req_rd_idx),
      .priv_i         (priv),
      .csr_addr_o     (csr_addr),
      .csr_re_o       (csr_re),
      .csr_we_o       (csr_we),
      .csr_wdata_o    (csr_wdata),
      .csr_rdata_i    (csr_rdata),
      .resp_valid_o   (resp_valid),
      .resp_ready_i   (resp_ready),
      .resp_rd_data_o (resp_rd_data),
      .resp_rd_idx_o  (resp_rd_idx),
      .resp_illegal_o (resp_illegal)
   );

   always_comb csr_rdata = csr_re ? mem[csr_addr] : 32'h0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (csr_we) mem[csr_addr] <= csr_wdata;
   end

   typedef struct {
      logic [2:0]  funct3;
      logic [11:0] addr;
      logic [31:0] rs1_val;
      logic [4:0]  rs1_idx;
      logic [4:0]  rd_idx;
      logic [1:0]  priv;
      logic        preload;
      logic [31:0] pre_val;
      int          exp_re_cyc;   // 0 = no read
      int          exp_we_cyc;   // 0 = no write
      logic [31:0] exp_wdata;
      logic [31:0] exp_rd;
      logic        exp_ill;
      int          exp_resp_cyc;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] v,
                            input logic [4:0] rs1, input logic [4:0] rd, input logic [1:0] p);
      req_valid   = 1'b1;
      req_funct3  = f3;
      req_addr    = a;
      req_rs1_val = v;
      req_rs1_idx = rs1;
      req_rd_idx  = rd;
      priv        = p;
   endtask

   // Starts and ends just after a falling edge
   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Issue one instruction, trace CSR activity per cycle, and check the response
   task automatic run_vec(input vec_t v, input string tag);
      int          re_cyc   = 0;
      int          we_cyc   = 0;
      int          re_cnt   = 0;
      int          we_cnt   = 0;
      int          resp_cyc = 0;
      logic [31:0] wd       = 32'h0;
      logic [11:0] re_addr  = 12'h0;
      logic        both     = 1'b0;
      if (v.preload) preload(v.addr, v.pre_val);
      check({tag, " req_ready"}, {31'h0, req_ready}, 32'h1);
      drive_req(v.funct3, v.addr, v.rs1_val, v.rs1_idx, v.rd_idx, v.priv);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         if (csr_re) begin re_cnt++; re_cyc = c; re_addr = csr_addr; end
         if (csr_we) begin we_cnt++; we_cyc = c; wd = csr_wdata; end
         if (csr_re && csr_we) both = 1'b1;
         if (resp_valid) begin resp_cyc = c; break; end
         @(negedge clk);
      end
      check({tag, " resp_cycle"}, resp_cyc, v.exp_resp_cyc);
      check({tag, " re_cycle"}, re_cyc, v.exp_re_cyc);
      check({tag, " we_cycle"}, we_cyc, v.exp_we_cyc);
      check({tag, " re_count"}, re_cnt, (v.exp_re_cyc != 0) ? 1 : 0);
      check({tag, " we_count"}, we_cnt, (v.exp_we_cyc != 0) ? 1 : 0);
      check({tag, " re_we_overlap"}, {31'h0, both}, 32'h0);
      if (v.exp_re_cyc != 0) check({tag, " re_addr"}, {20'h0, re_addr}, {20'h0, v.addr});
      check({tag, " wdata"}, wd, v.exp_wdata);
      check({tag, " rd_data"}, resp_rd_data, v.exp_rd);
      check({tag, " rd_idx"}, {27'h0, resp_rd_idx}, {27'h0, v.rd_idx});
      check({tag, " illegal"}, {31'h0, resp_illegal}, {31'h0, v.exp_ill});
      @(negedge clk);
      check({tag, " ready_after"}, {30'h0, req_ready, resp_valid}, 32'h2);
   endtask

   // All outputs must be zero except req_ready
   task automatic check_idle_outputs(input string tag);
      check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
      check({tag, " ctl"}, {28'h0, csr_re, csr_we, resp_valid, resp_illegal}, 32'h0);
      check({tag, " addr"}, {20'h0, csr_addr}, 32'h0);
      check({tag, " wdata"}, csr_wdata, 32'h0);
      check({tag, " rd_data"}, resp_rd_data, 32'h0);
      check({tag, " rd_idx"}, {27'h0, resp_rd_idx}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          rc;
      logic        we_seen;
      logic [31:0] held;
      //         f3      addr    rs1_val       idx    rd     priv  pl    pre_val      re we wdata        rd_data      ill resp
      vecs[0]  = '{3'b001, 12'h340, 32'h12345678, 5'd7,  5'd5,  2'b11, 1'b1, 32'hAAAA0000, 1, 2, 32'h12345678, 32'hAAAA0000, 1'b0, 3};
      vecs[1]  = '{3'b010, 12'h300, 32'h00000008, 5'd2,  5'd6,  2'b11, 1'b1, 32'h00001800, 1, 2, 32'h00001808, 32'h00001800, 1'b0, 3};
      vecs[2]  = '{3'b011, 12'h300, 32'h00001000, 5'd3,  5'd7,  2'b11, 1'b0, 32'h0,        1, 2, 32'h00000808, 32'h00001808, 1'b0, 3};
      vecs[3]  = '{3'b110, 12'hB00, 32'hFFFFFFFF, 5'd0,  5'd3,  2'b11, 1'b1, 32'h00000055, 1, 0, 32'h0,        32'h00000055, 1'b0, 2};
      vecs[4]  = '{3'b101, 12'h340, 32'hFFFFFFFF, 5'd31, 5'd0,  2'b11, 1'b0, 32'h0,        0, 1, 32'h0000001F, 32'h0,        1'b0, 2};
      vecs[5]  = '{3'b111, 12'h340, 32'h00000000, 5'd15, 5'd9,  2'b11, 1'b0, 32'h0,        1, 2, 32'h00000010, 32'h0000001F, 1'b0, 3};
      vecs[6]  = '{3'b001, 12'hC00, 32'h00000000, 5'd1,  5'd4,  2'b11, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1};
      vecs[7]  = '{3'b010, 12'hC00, 32'h00000000, 5'd0,  5'd8,  2'b11, 1'b1, 32'h00C0FFEE, 1, 0, 32'h0,        32'h00C0FFEE, 1'b0, 2};
      vecs[8]  = '{3'b001, 12'h300, 32'h00000012, 5'd1,  5'd1,  2'b00, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1};
      vecs[9]  = '{3'b100, 12'h340, 32'h00000005, 5'd1,  5'd2,  2'b11, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1};
      vecs[10] = '{3'b000, 12'h340, 32'h00000005, 5'd1,  5'd2,  2'b11, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1};
      vecs[11] = '{3'b001, 12'h100, 32'h000000FF, 5'd1,  5'd1,  2'b01, 1'b1, 32'h00000022, 1, 2, 32'h000000FF, 32'h00000022, 1'b0, 3};
      vecs[12] = '{3'b001, 12'h340, 32'h000000FF, 5'd1,  5'd10, 2'b01, 1'b0, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1};

      rst        = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      pl_en      = 1'b0;
      pl_addr    = 12'h0;
      pl_data    = 32'h0;
      drive_req(3'b000, 12'h0, 32'h0, 5'd0, 5'd0, 2'b11);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("reset");

      for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: response held for 4 cycles while another request is offered
      preload(12'h340, 32'h0BADF00D);
      resp_ready = 1'b0;
      drive_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd2, 5'd2, 2'b11);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rc = 0;
      for (int c = 1; c <= 8; c++) begin
         if (resp_valid) begin rc = c; break; end
         @(negedge clk);
      end
      check("hold resp_cycle", rc, 3);
      held = resp_rd_data;
      check("hold first rd_data", held, 32'h0BADF00D);
      for (int k = 0; k < 4; k++) begin
         drive_req(3'b001, 12'h340, 32'h11111111, 5'd1, 5'd9, 2'b11);
         @(negedge clk);
         check($sformatf("hold%0d valid_ready", k), {30'h0, resp_valid, req_ready}, 32'h2);
         check($sformatf("hold%0d csr_activity", k), {30'h0, csr_re, csr_we}, 32'h0);
         check($sformatf("hold%0d rd_data", k), resp_rd_data, 32'h0BADF00D);
         check($sformatf("hold%0d rd_idx", k), {27'h0, resp_rd_idx}, 32'd2);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      check("hold release", {30'h0, req_ready, resp_valid}, 32'h2);
      check("hold mem", mem[12'h340], 32'hDEADBEEF);

      // Reset during the READ cycle of a CSRRW must suppress the write
      preload(12'h340, 32'h13572468);
      drive_req(3'b001, 12'h340, 32'h77777777, 5'd3, 5'd5, 2'b11);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid in_read", {31'h0, csr_re}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("rstmid");
      we_seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (csr_we) we_seen = 1'b1;
      end
      check("rstmid no_we", {31'h0, we_seen}, 32'h0);
      check("rstmid mem", mem[12'h340], 32'h13572468);
      run_vec(vecs[0], "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
